quad_velocity: RTL and testbench

Periodic velocity estimator that sits directly downstream of the quadrature decoder. Samples the decoder's 32-bit position count once every `PERIOD` clocks and computes the signed position delta per window. Saturates the delta to `VEL_W` bits and presents it to the DSP control loop with a one-cycle valid strobe.

---
 rtl/quad_velocity.sv | 168 ++++++++++++++++
 tb/tb_quad_velocity.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/quad_velocity.sv
// quad_velocity: periodic velocity estimator downstream of the quadrature decoder.
// Samples the position count once every PERIOD clocks, forms the signed
// modular delta against the previous sample, saturates it to VEL_W bits and
// presents it with a one-cycle valid strobe.
//
// Optional build macro: QUAD_VEL_AVG_EN -- output becomes the floored average
// of the last 4 deltas (one extra pipeline stage, output held off until
// 4 deltas have been collected since entering RUN).
//
// Ports:
//   clk        in   single clock, posedge
//   rst        in   synchronous active-high reset
//   en         in   estimator enable; low returns to IDLE
//   count      in   CNT_W-bit position count (modulo 2^CNT_W)
//   vel        out  signed VEL_W-bit velocity, counts per window, held
//   vel_valid  out  one-cycle pulse when vel updates
//   vel_sat    out  high when the current vel was clipped
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | disabled, timebase held at 0
// PRIME | first window running; tick captures the reference sample only
// RUN   | each tick captures a sample and produces a delta
module quad_velocity #(
  parameter int PERIOD = 10000,
  parameter int CNT_W  = 32,
  parameter int VEL_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [CNT_W-1:0]        count,
  output logic signed [VEL_W-1:0] vel,
  output logic                    vel_valid,
  output logic                    vel_sat
);

  localparam int TB_W = $clog2(PERIOD);
  localparam logic [TB_W-1:0] TB_LAST = TB_W'(PERIOD - 1);
  localparam logic signed [CNT_W+1:0] SAT_MAX = {{(CNT_W+3-VEL_W){1'b0}}, {(VEL_W-1){1'b1}}};
  localparam logic signed [CNT_W+1:0] SAT_MIN = {{(CNT_W+3-VEL_W){1'b1}}, {(VEL_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  state_t           state, state_nxt;
  logic [TB_W-1:0]  tb;
  logic             tick;
  logic             sample_run;
  logic [CNT_W-1:0] prev;
  logic [CNT_W-1:0] delta;
  logic             d_v;

  // Returns {sat_flag, clipped value}.
  function automatic logic [VEL_W:0] saturate(input logic signed [CNT_W+1:0] v);
    if (v > SAT_MAX)
      return {1'b1, SAT_MAX[VEL_W-1:0]};
    else if (v < SAT_MIN)
      return {1'b1, SAT_MIN[VEL_W-1:0]};
    else
      return {1'b0, v[VEL_W-1:0]};
  endfunction

  function automatic logic [CNT_W+1:0] sext(input logic [CNT_W-1:0] x);
    return {{2{x[CNT_W-1]}}, x};
  endfunction

  assign tick       = en && (state != IDLE) && (tb == TB_LAST);
  assign sample_run = tick && (state == RUN);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = PRIME;
      PRIME:   if (tick) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
    if (!en) state_nxt = IDLE;
  end

  // State, timebase and sample capture (stage 1).
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      tb    <= '0;
      prev  <= '0;
      delta <= '0;
      d_v   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (!en || state == IDLE || tick)
        tb <= '0;
      else
        tb <= tb + 1'b1;
      if (tick)
        prev <= count;
      // Modular subtraction: reading the result as signed gives the correct
      // delta across the counter wrap.
      if (sample_run)
        delta <= count - prev;
      d_v <= sample_run;
    end
  end

`ifdef QUAD_VEL_AVG_EN
  logic [CNT_W-1:0]        h0, h1, h2;
  logic [1:0]              hcnt;
  logic signed [CNT_W+1:0] sum;
  logic                    sum_v;

  // Stage 2: sum of the newest delta and the three before it. hcnt counts
  // prior deltas; once three are held the window of four is full.
  always_ff @(posedge clk) begin
    if (rst) begin
      h0    <= '0;
      h1    <= '0;
      h2    <= '0;
      hcnt  <= '0;
      sum   <= '0;
      sum_v <= 1'b0;
    end else begin
      sum_v <= 1'b0;
      if (d_v) begin
        h0  <= delta;
        h1  <= h0;
        h2  <= h1;
        sum <= sext(delta) + sext(h0) + sext(h1) + sext(h2);
        if (hcnt == 2'd3)
          sum_v <= 1'b1;
        else
          hcnt <= hcnt + 1'b1;
      end else if (state == IDLE) begin
        h0   <= '0;
        h1   <= '0;
        h2   <= '0;
        hcnt <= '0;
      end
    end
  end

  // Stage 3: floored divide by 4, then saturate.
  always_ff @(posedge clk) begin
    if (rst) begin
      vel       <= '0;
      vel_sat   <= 1'b0;
      vel_valid <= 1'b0;
    end else begin
      vel_valid <= sum_v;
      if (sum_v)
        {vel_sat, vel} <= saturate(sum >>> 2);
    end
  end
`else
  // Stage 2: saturate the raw delta.
  always_ff @(posedge clk) begin
    if (rst) begin
      vel       <= '0;
      vel_sat   <= 1'b0;
      vel_valid <= 1'b0;
    end else begin
      vel_valid <= d_v;
      if (d_v)
        {vel_sat, vel} <= saturate(sext(delta));
    end
  end
`endif

endmodule

// File: tb/tb_quad_velocity.sv
module tb_quad_velocity;
  localparam int PERIOD = 8;
  localparam int CNT_W  = 32;
  localparam int VEL_W  = 16;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    en = 1'b0;
  logic [CNT_W-1:0]        count = '0;
  logic signed [VEL_W-1:0] vel;
  logic                    vel_valid;
  logic                    vel_sat;

  always #5 clk = ~clk;

  quad_velocity #(.PERIOD(PERIOD), .CNT_W(CNT_W), .VEL_W(VEL_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .count     (count),
    .vel       (vel),
    .vel_valid (vel_valid),
    .vel_sat   (vel_sat)
  );

  typedef struct {
    longint v;
    bit     s;
    int     at;
  } exp_t;

  exp_t        sb[$];
  longint      hist[$];
  int unsigned stim[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic signed [63:0] got,
                           input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Model of one new delta; pushes the expected output, if any.
  task automatic push_delta(input int unsigned cur, input int unsigned prv, input int at);
    longint d;
    longint v;
    bit     s;
    int     when;
    d    = longint'(int'(cur - prv));
    when = at;
    hist.push_back(d);
`ifdef QUAD_VEL_AVG_EN
    if (hist.size() > 4) void'(hist.pop_front());
    if (hist.size() < 4) return;
    d    = (hist[0] + hist[1] + hist[2] + hist[3]) >>> 2;
    when = at + 1;
`endif
    if (d > 32767) begin
      v = 32767; s = 1'b1;
    end else if (d < -32768) begin
      v = -32768; s = 1'b1;
    end else begin
      v = d; s = 1'b0;
    end
    sb.push_back('{v, s, when});
  endtask

  // Enable, present stim[k] during window k, drop en right after the last
  // sample edge, then idle long enough to catch any stray pulse.
  task automatic run_seq();
    int e0;
    hist.delete();
    @(negedge clk);
    count = stim[0];
    en    = 1'b1;
    e0    = cyc + 1;
    for (int k = 1; k < stim.size(); k++) begin
      while (cyc != e0 + k * PERIOD) @(negedge clk);
      count = stim[k];
      push_delta(stim[k], stim[k-1], e0 + (k + 1) * PERIOD + 1);
    end
    while (cyc != e0 + stim.size() * PERIOD) @(negedge clk);
    en = 1'b0;
    repeat (3 * PERIOD) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst && vel_valid) begin
      if (sb.size() == 0) begin
        check_val("spurious_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_val("vel", vel, e.v);
        check_val("vel_sat", {63'd0, vel_sat}, {63'd0, e.s});
        check_val("latency", cyc, e.at);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    repeat (3) @(negedge clk);
    check_val("rst_vel", vel, 0);
    check_val("rst_valid", {63'd0, vel_valid}, 0);
    check_val("rst_sat", {63'd0, vel_sat}, 0);
    rst = 1'b0;

    stim = '{100, 105, 110, 115, 120};
    run_seq();
    stim = '{50, 47, 44, 41};
    run_seq();
    stim = '{32'hFFFF_FFF0, 32'h0000_0010, 32'hFFFF_FFF0};
    run_seq();
    stim = '{0, 4, 12, 24, 17, 17};
    run_seq();
    stim = '{0, 40000, 0, 10};
    run_seq();

    // Reset one cycle after a sample edge flushes the pending delta.
    hist.delete();
    @(negedge clk);
    count = 0;
    en    = 1'b1;
    e0    = cyc + 1;
    while (cyc != e0 + PERIOD) @(negedge clk);
    count = 7;
    while (cyc != e0 + 2 * PERIOD) @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_val("flush_vel", vel, 0);
    check_val("flush_sat", {63'd0, vel_sat}, 0);
    check_val("flush_valid", {63'd0, vel_valid}, 0);
    repeat (3 * PERIOD) @(negedge clk);

    // Restart from IDLE after reset: priming and latency must start over.
    stim = '{1000, 1003, 1009};
    run_seq();

    check_val("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
